sync_down_counter: RTL
======================

Name: sync_down_counter

Overview:
Synchronous, loadable down counter. It is the counting-direction complement of the team's ripple up counter.
- All state bits are clocked from a single clock, so the count never shows ripple glitches.
- Supports one-shot and auto-reload (periodic) modes.
- Emits a registered terminal-count pulse.
- Used as a programmable delay or interval timer beside the up-counter blocks.

Parameters:
WIDTH, 4, counter and load-value width in bits (minimum 2)

Ports:
clk  input  1  system clock; all state updates on posedge
rst_n  input  1  reset, asynchronous assert, active-low
load  input  1  load request; samples load_val this cycle
load_val  input  WIDTH  start/reload value
en  input  1  count enable; decrement when high and busy
mode  input  1  0 = one-shot, 1 = auto-reload; sampled every cycle
count  output  WIDTH  current count (registered)
busy  output  1  counter armed and non-zero (registered)
zero  output  1  combinational, count == 0
tc_pulse  output  1  registered single-cycle terminal-count pulse

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (clk, rst_n).
  - On rst_n low, immediately: count=0, reload_reg=0, busy=0, tc_pulse=0; zero=1 as a consequence.
  - After rst_n deasserts, the first action is taken on the next posedge clk.
- Internal state: count, reload_reg (WIDTH bits), busy, tc_pulse. No other storage.
- Priority per posedge: load > decrement > hold.
- Load (load=1):
  - count <= load_val; reload_reg <= load_val; busy <= (load_val != 0); tc_pulse <= 0.
  - en is ignored that cycle; a load never decrements.
  - A load during an active count restarts the counter from load_val.
- Decrement (load=0, en=1, busy=1):
  - count > 1: count <= count-1; tc_pulse <= 0.
  - count == 1, mode=0: count <= 0; busy <= 0; tc_pulse <= 1.
  - count == 1, mode=1: count <= reload_reg; busy stays 1; tc_pulse <= 1.
- Hold (all other cases): count, busy and reload_reg unchanged; tc_pulse <= 0.
- Pulse timing: tc_pulse is high for exactly one cycle.
  - One-shot: it coincides with count first reading 0.
  - Auto-reload: it coincides with count reading reload_reg.
- Latency: load at edge N with value V and en held high gives the terminal edge at N+V. tc_pulse is visible after that edge.
- Auto-reload period: exactly reload_reg enabled cycles between tc_pulses.
  - reload_reg=1 → tc_pulse high on every enabled cycle, count stays 1.
- en low mid-count: freezes count and does not generate tc_pulse. Counting resumes where it stopped.
- No wrap-around: when busy=0 the count stays at 0 whatever en is. Never decrement 0 to all-ones.
- load_val=0: busy=0, count=0, no tc_pulse, in either mode.
- Mode changed mid-count: takes effect only at the count==1 decision.
- Arithmetic: unsigned WIDTH-bit; decrement only applied when count ≥ 1, so no underflow.
- Reset mid-count: aborts immediately with no tc_pulse; reload_reg is cleared.

Decomposition:
- Shared package ctr_pkg: MODE_ONESHOT=1'b0 and MODE_RELOAD=1'b1 constants, plus default WIDTH. The up-counter blocks reuse the package.
- One sub-module is natural: down_count_core. It holds the count register, the next-value mux (load / decrement / reload) and the count==1 detect.
- The top level adds busy, the tc_pulse register and zero.

Test Plan:
- Reset: assert rst_n=0 mid-clock-cycle with count=9 → count=0, busy=0, tc_pulse=0, zero=1 immediately (asynchronous, no clk edge needed).
- One-shot: WIDTH=4, load_val=5, mode=0, en=1 from next cycle.
  - count reads 5,4,3,2,1,0; tc_pulse high only in the cycle count=0; busy falls with it.
  - Count then holds 0 for 10 more cycles, with no wrap to 15.
- Auto-reload: load_val=3, mode=1, en=1.
  - count sequence 3,2,1,3,2,1,3…; tc_pulse every 3rd cycle, aligned with each 3.
  - reload_reg=1 → tc_pulse every cycle.
- Enable gating: load_val=4, en pattern 1,0,0,1,1,1 → count 4,3,3,3,2,1,0; tc_pulse once, at the final 0.
- Load priority: while count=2 and en=1, drive load=1 with load_val=7 → next count=7 (not 1), tc_pulse=0.
- Zero load: load_val=0 with en=1 and mode=1 → busy=0, count=0, tc_pulse never asserts over 20 cycles.

Source files
------------

// File: rtl/ctr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ctr_pkg
// Description : Shared constants for the counter family (mode encodings and
//               default width).
// Revision    : 1.0 - initial release
// ============================================================================
package ctr_pkg;

    localparam int unsigned DEFAULT_WIDTH = 4;

    localparam logic MODE_ONESHOT = 1'b0;
    localparam logic MODE_RELOAD  = 1'b1;

endpackage : ctr_pkg
`default_nettype wire

// File: rtl/down_count_core.sv
`default_nettype none
// ============================================================================
// Module      : down_count_core
// Description : Count and reload registers with the load/decrement/reload
//               next-value mux and the count==1 detect.
// Revision    : 1.0 - initial release
// ============================================================================
module down_count_core
    import ctr_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_dec,
    input  logic             i_mode,
    output logic [WIDTH-1:0] o_count,
    output logic             o_is_one
);

    localparam logic [WIDTH-1:0] c_one = WIDTH'(1);

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_reload;
    logic [WIDTH-1:0] w_count_nxt;
    logic [WIDTH-1:0] w_reload_nxt;
    logic             w_is_one;

    assign w_is_one = (r_count == c_one);

    always_comb begin
        w_count_nxt  = r_count;
        w_reload_nxt = r_reload;
        if (i_load) begin
            w_count_nxt  = i_load_val;
            w_reload_nxt = i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            // The last step either parks at zero or wraps to the stored period.
            if (w_is_one) begin
                w_count_nxt = (i_mode == MODE_RELOAD) ? r_reload : '0;
            end else begin
                w_count_nxt = r_count - c_one;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count  <= '0;
            r_reload <= '0;
        end else begin
            r_count  <= w_count_nxt;
            r_reload <= w_reload_nxt;
        end
    end

    assign o_count  = r_count;
    assign o_is_one = w_is_one;

endmodule : down_count_core
`default_nettype wire

// File: rtl/sync_down_counter.sv
`default_nettype none
// ============================================================================
// Module      : sync_down_counter
// Description : Loadable synchronous down counter with one-shot / auto-reload
//               modes and a registered terminal-count pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_down_counter
    import ctr_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             mode,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             zero,
    output logic             tc_pulse
);

    logic             r_busy;
    logic             r_tc;
    logic             w_busy_nxt;
    logic             w_tc_nxt;
    logic             w_dec;
    logic             w_is_one;
    logic [WIDTH-1:0] w_count;

    // Load has priority, so a decrement is only qualified when no load is present.
    assign w_dec = en & r_busy & ~load;

    down_count_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (load),
        .i_load_val (load_val),
        .i_dec      (w_dec),
        .i_mode     (mode),
        .o_count    (w_count),
        .o_is_one   (w_is_one)
    );

    always_comb begin
        w_busy_nxt = r_busy;
        w_tc_nxt   = 1'b0;
        if (load) begin
            w_busy_nxt = (load_val != '0);
        end else if (w_dec && w_is_one) begin
            w_tc_nxt = 1'b1;
            if (mode == MODE_ONESHOT) begin
                w_busy_nxt = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_tc   <= 1'b0;
        end else begin
            r_busy <= w_busy_nxt;
            r_tc   <= w_tc_nxt;
        end
    end

    assign count    = w_count;
    assign busy     = r_busy;
    assign tc_pulse = r_tc;
    assign zero     = (w_count == '0);

endmodule : sync_down_counter
`default_nettype wire
